// File: rtl/rib_mem_responder_if.sv
// RIB bus bundle between the core's fetch/data master ports and the memory responder.
// Member names follow the responder's port naming so waveforms read the same on both sides.
interface rib_mem_responder_if;
    logic        pc_req_i;
    logic [31:0] pc_addr_i;
    logic [31:0] pc_rdata_o;
    logic        pc_ready_o;
    logic        ex_req_i;
    logic        ex_we_i;
    logic [31:0] ex_addr_i;
    logic [31:0] ex_wdata_i;
    logic [31:0] ex_rdata_o;
    logic        ex_ready_o;
    logic        hold_o;
    logic        busy_o;

    modport master (
        output pc_req_i, pc_addr_i, ex_req_i, ex_we_i, ex_addr_i, ex_wdata_i,
        input  pc_rdata_o, pc_ready_o, ex_rdata_o, ex_ready_o, hold_o, busy_o
    );

    modport slave (
        input  pc_req_i, pc_addr_i, ex_req_i, ex_we_i, ex_addr_i, ex_wdata_i,
        output pc_rdata_o, pc_ready_o, ex_rdata_o, ex_ready_o, hold_o, busy_o
    );
endinterface

// File: rtl/rib_mem_responder.sv
// Single-port word memory serving the fetch and data RIB masters with round-robin
// arbitration, WAIT_CYCLES wait states and single-cycle registered ready pulses.
module rib_mem_responder #(
    parameter int          DEPTH_WORDS = 4096,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    rib_mem_responder_if.slave bus
);
    localparam int          AW        = (DEPTH_WORDS > 2) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) << 2;
    localparam logic [2:0]  WAIT_INIT = 3'(WAIT_CYCLES);
    localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_gnt_ex;
    logic          r_last_ex;
    logic          r_we;
    logic          r_in_range;
    logic [AW-1:0] r_idx;
    logic [31:0]   r_wdata;
    logic [2:0]    r_cnt;
    logic          r_pc_ready;
    logic          r_ex_ready;
    logic          r_hold;
    logic          r_busy;
    logic [31:0]   r_pc_rdata;
    logic [31:0]   r_ex_rdata;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_any_req;
    logic          w_pick_ex;
    logic [31:0]   w_req_addr;
    logic [31:0]   w_req_off;
    logic          w_accept;
    logic          w_access;
    logic          w_acc_ex;
    logic          w_acc_we;
    logic          w_acc_inr;
    logic [AW-1:0] w_acc_idx;
    logic [31:0]   w_acc_wdata;
    logic [31:0]   w_rd_data;

    // Arbitration, address decode and selection of the access performed on entry to RESP.
    // With no wait states the access happens on the acceptance edge, so it uses the live request.
    always_comb begin
        w_any_req  = bus.pc_req_i | bus.ex_req_i;
        w_pick_ex  = bus.ex_req_i & (~bus.pc_req_i | ~r_last_ex);
        w_req_addr = w_pick_ex ? bus.ex_addr_i : bus.pc_addr_i;
        w_req_off  = w_req_addr - BASE_ADDR;
        w_accept   = (r_state == S_IDLE) && w_any_req;
        w_access   = (w_accept && NO_WAIT) || ((r_state == S_WAIT) && (r_cnt == 3'd1));
        if (r_state == S_IDLE) begin
            w_acc_ex    = w_pick_ex;
            w_acc_we    = w_pick_ex & bus.ex_we_i;
            w_acc_inr   = ({1'b0, w_req_off} < MEM_BYTES);
            w_acc_idx   = AW'(w_req_off >> 2);
            w_acc_wdata = bus.ex_wdata_i;
        end else begin
            w_acc_ex    = r_gnt_ex;
            w_acc_we    = r_we;
            w_acc_inr   = r_in_range;
            w_acc_idx   = r_idx;
            w_acc_wdata = r_wdata;
        end
        w_rd_data = w_acc_inr ? r_mem[w_acc_idx] : 32'h0;
    end

    // Control FSM with registered ready/hold/busy and per-port read data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_gnt_ex   <= 1'b0;
            r_last_ex  <= 1'b0;
            r_we       <= 1'b0;
            r_in_range <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= 32'h0;
            r_cnt      <= 3'd0;
            r_pc_ready <= 1'b0;
            r_ex_ready <= 1'b0;
            r_hold     <= 1'b0;
            r_busy     <= 1'b0;
            r_pc_rdata <= 32'h0;
            r_ex_rdata <= 32'h0;
        end else begin
            r_pc_ready <= 1'b0;
            r_ex_ready <= 1'b0;
            if (w_access) begin
                if (w_acc_ex) begin
                    r_ex_ready <= 1'b1;
                    if (!w_acc_we) begin
                        r_ex_rdata <= w_rd_data;
                    end
                end else begin
                    r_pc_ready <= 1'b1;
                    r_pc_rdata <= w_rd_data;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_gnt_ex   <= w_pick_ex;
                        r_last_ex  <= w_pick_ex;
                        r_we       <= w_acc_we;
                        r_in_range <= w_acc_inr;
                        r_idx      <= w_acc_idx;
                        r_wdata    <= bus.ex_wdata_i;
                        r_cnt      <= WAIT_INIT;
                        r_hold     <= w_pick_ex;
                        r_busy     <= 1'b1;
                        r_state    <= NO_WAIT ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_hold  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_hold  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Storage array; contents survive reset, and a write lands only on its access edge.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_access && w_acc_we && w_acc_inr) begin
            r_mem[w_acc_idx] <= w_acc_wdata;
        end
    end

    assign bus.pc_rdata_o = r_pc_rdata;
    assign bus.pc_ready_o = r_pc_ready;
    assign bus.ex_rdata_o = r_ex_rdata;
    assign bus.ex_ready_o = r_ex_ready;
    assign bus.hold_o     = r_hold;
    assign bus.busy_o     = r_busy;
endmodule

// File: tb/tb_rib_mem_responder.sv
// Self-checking bench for rib_mem_responder: directed plan steps plus randomized
// single-master traffic compared against a word-array reference model.
module tb_rib_mem_responder;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rib_mem_responder_if b1 ();
    rib_mem_responder_if b0 ();

    rib_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1), .BASE_ADDR(BASE)) dut1 (
        .clk_i(clk), .rst_i(rst), .bus(b1)
    );
    rib_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_0000)) dut0 (
        .clk_i(clk), .rst_i(rst), .bus(b0)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] exp_pc_rd = 32'h0;
    logic [31:0] exp_ex_rd = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction on the WAIT_CYCLES=1 instance: ready expected 2 cycles after acceptance.
    task automatic txn1(input bit is_ex, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input string tag);
        logic [31:0] off;
        bit          inr;
        bit          wr;
        bit          seen;
        logic [31:0] exp_rd;
        off    = addr - BASE;
        inr    = (off < 32'(DEPTH * 4));
        wr     = is_ex && we;
        exp_rd = inr ? model[int'(off >> 2)] : 32'h0;
        seen   = 1'b0;
        @(negedge clk);
        if (is_ex) begin
            b1.ex_req_i = 1'b1; b1.ex_we_i = we; b1.ex_addr_i = addr; b1.ex_wdata_i = wdata;
        end else begin
            b1.pc_req_i = 1'b1; b1.pc_addr_i = addr;
        end
        #1 chk({tag, "_hold_pre"}, 32'(b1.hold_o), 32'd0);
        @(posedge clk);
        for (int k = 1; k <= 8 && !seen; k++) begin
            @(negedge clk);
            chk({tag, "_hold"}, 32'(b1.hold_o), 32'(is_ex));
            chk({tag, "_busy"}, 32'(b1.busy_o), 32'd1);
            if (is_ex ? b1.ex_ready_o : b1.pc_ready_o) begin
                seen = 1'b1;
                chk({tag, "_lat"}, 32'(k), 32'd2);
                chk({tag, "_other_rdy"}, 32'(is_ex ? b1.pc_ready_o : b1.ex_ready_o), 32'd0);
                if (is_ex) begin
                    if (!wr) exp_ex_rd = exp_rd;
                    chk({tag, "_ex_rdata"}, b1.ex_rdata_o, exp_ex_rd);
                    chk({tag, "_pc_keep"}, b1.pc_rdata_o, exp_pc_rd);
                end else begin
                    exp_pc_rd = exp_rd;
                    chk({tag, "_pc_rdata"}, b1.pc_rdata_o, exp_pc_rd);
                    chk({tag, "_ex_keep"}, b1.ex_rdata_o, exp_ex_rd);
                end
            end
        end
        chk({tag, "_ready_seen"}, 32'(seen), 32'd1);
        b1.ex_req_i = 1'b0;
        b1.pc_req_i = 1'b0;
        if (wr && inr) model[int'(off >> 2)] = wdata;
        @(negedge clk);
        chk({tag, "_rdy_after"}, 32'({b1.pc_ready_o, b1.ex_ready_o}), 32'd0);
        chk({tag, "_idle_after"}, 32'({b1.busy_o, b1.hold_o}), 32'd0);
    endtask

    task automatic chk_reset1(input string tag);
        chk({tag, "_pc_rdy"}, 32'(b1.pc_ready_o), 32'd0);
        chk({tag, "_ex_rdy"}, 32'(b1.ex_ready_o), 32'd0);
        chk({tag, "_hold"}, 32'(b1.hold_o), 32'd0);
        chk({tag, "_busy"}, 32'(b1.busy_o), 32'd0);
        chk({tag, "_pc_rd"}, b1.pc_rdata_o, 32'h0);
        chk({tag, "_ex_rd"}, b1.ex_rdata_o, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr;
        logic [31:0] old20;
        bit          rnd_ex;
        bit          rnd_we;
        int          sel;
        int          rdy_port [$];
        int          rdy_cyc  [$];

        b1.pc_req_i = 1'b0; b1.pc_addr_i = 32'h0; b1.ex_req_i = 1'b0; b1.ex_we_i = 1'b0;
        b1.ex_addr_i = 32'h0; b1.ex_wdata_i = 32'h0;
        b0.pc_req_i = 1'b0; b0.pc_addr_i = 32'h0; b0.ex_req_i = 1'b0; b0.ex_we_i = 1'b0;
        b0.ex_addr_i = 32'h0; b0.ex_wdata_i = 32'h0;

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset1("reset");
        chk("reset_dut0", 32'({b0.pc_ready_o, b0.ex_ready_o, b0.hold_o, b0.busy_o}), 32'd0);
        rst = 1'b0;

        // Fill the array through EX writes so every later read has a known value.
        for (int i = 0; i < DEPTH; i++) begin
            txn1(1'b1, 1'b1, BASE + 32'(i * 4), $urandom, "preload");
        end

        // Plan: EX write then PC readback of BASE+0x10.
        txn1(1'b1, 1'b1, BASE + 32'h10, 32'hDEADBEEF, "wr10");
        txn1(1'b0, 1'b0, BASE + 32'h10, 32'h0, "rd10");
        chk("rd10_value", exp_pc_rd, 32'hDEADBEEF);
        txn1(1'b1, 1'b0, BASE + 32'h10, 32'h0, "exrd10");
        chk("exrd10_value", exp_ex_rd, 32'hDEADBEEF);

        // Out-of-range read returns zero; out-of-range write leaves word 0 intact.
        txn1(1'b1, 1'b0, BASE + 32'(DEPTH * 4), 32'h0, "oor_rd");
        chk("oor_rd_value", b1.ex_rdata_o, 32'h0);
        txn1(1'b1, 1'b1, BASE + 32'(DEPTH * 4), 32'h1234_5678, "oor_wr");
        txn1(1'b1, 1'b0, BASE, 32'h0, "word0");
        txn1(1'b1, 1'b1, BASE - 32'd4, 32'hCAFE_F00D, "below_wr");
        txn1(1'b0, 1'b0, BASE + 32'(DEPTH * 4 - 4), 32'h0, "lastword");

        // Randomized single-master traffic.
        for (int n = 0; n < 40; n++) begin
            rnd_ex = 1'($urandom_range(0, 1));
            rnd_we = 1'($urandom_range(0, 1));
            sel    = int'($urandom_range(0, 9));
            if (sel == 0)      addr = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 15) * 4);
            else if (sel == 1) addr = BASE - 32'd4;
            else               addr = BASE + 32'($urandom_range(0, DEPTH - 1) * 4) + 32'($urandom_range(0, 3));
            txn1(rnd_ex, rnd_we, addr, $urandom, "rand");
        end

        // Reset during WAIT of a write to 0x20: write discarded, no ready pulse.
        old20 = model[8];
        @(negedge clk);
        b1.ex_req_i = 1'b1; b1.ex_we_i = 1'b1; b1.ex_addr_i = BASE + 32'h20; b1.ex_wdata_i = ~old20;
        @(negedge clk);
        chk("midrst_hold", 32'(b1.hold_o), 32'd1);
        chk("midrst_rdy_wait", 32'(b1.ex_ready_o), 32'd0);
        rst = 1'b1;
        b1.ex_req_i = 1'b0;
        @(negedge clk);
        chk_reset1("midrst");
        rst = 1'b0;
        exp_pc_rd = 32'h0;
        exp_ex_rd = 32'h0;
        @(negedge clk);
        chk("midrst_no_rdy", 32'(b1.ex_ready_o), 32'd0);
        txn1(1'b1, 1'b0, BASE + 32'h20, 32'h0, "rd20");
        chk("rd20_old", exp_ex_rd, old20);

        // Both masters held high from reset release: EX, PC, EX, PC, each 3 cycles apart.
        rst = 1'b1;
        b1.pc_req_i = 1'b1; b1.pc_addr_i = BASE + 32'h10;
        b1.ex_req_i = 1'b1; b1.ex_we_i = 1'b0; b1.ex_addr_i = BASE + 32'h20;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            chk("conf_not_both", 32'(b1.pc_ready_o & b1.ex_ready_o), 32'd0);
            if (b1.ex_ready_o) begin
                rdy_port.push_back(1); rdy_cyc.push_back(k);
                chk("conf_ex_rdata", b1.ex_rdata_o, model[8]);
            end
            if (b1.pc_ready_o) begin
                rdy_port.push_back(0); rdy_cyc.push_back(k);
                chk("conf_pc_rdata", b1.pc_rdata_o, model[4]);
            end
        end
        b1.pc_req_i = 1'b0;
        b1.ex_req_i = 1'b0;
        chk("conf_count", 32'(rdy_port.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < rdy_port.size()) begin
                chk("conf_order", 32'(rdy_port[i]), 32'((i % 2 == 0) ? 1 : 0));
                chk("conf_cycle", 32'(rdy_cyc[i]), 32'(2 + 3 * i));
            end
        end
        @(negedge clk);
        chk("conf_idle", 32'(b1.busy_o), 32'd0);

        // WAIT_CYCLES=0 instance: write words 0 and 1, then back-to-back PC reads.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            b0.ex_req_i = 1'b1; b0.ex_we_i = 1'b1; b0.ex_addr_i = 32'(i * 4); b0.ex_wdata_i = 32'hA5A5_0000 + 32'(i);
            @(negedge clk);
            chk("w0_wr_rdy", 32'(b0.ex_ready_o), 32'd1);
            chk("w0_wr_hold", 32'(b0.hold_o), 32'd1);
            b0.ex_req_i = 1'b0;
        end
        @(negedge clk);
        b0.pc_req_i = 1'b1; b0.pc_addr_i = 32'h0;
        @(negedge clk);
        chk("w0_rd0_rdy", 32'(b0.pc_ready_o), 32'd1);
        chk("w0_rd0_data", b0.pc_rdata_o, 32'hA5A5_0000);
        b0.pc_addr_i = 32'h4;
        @(negedge clk);
        chk("w0_gap_rdy", 32'(b0.pc_ready_o), 32'd0);
        chk("w0_gap_busy", 32'(b0.busy_o), 32'd0);
        @(negedge clk);
        chk("w0_rd1_rdy", 32'(b0.pc_ready_o), 32'd1);
        chk("w0_rd1_data", b0.pc_rdata_o, 32'hA5A5_0001);
        chk("w0_rd1_hold", 32'(b0.hold_o), 32'd0);
        b0.pc_req_i = 1'b0;
        @(negedge clk);
        chk("w0_end_rdy", 32'(b0.pc_ready_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
